// File: rtl/seg_scan_ctrl_pkg.sv
// rtl/seg_scan_ctrl_pkg.sv - shared seven-segment glyph constants and scan FSM states
package seg_scan_ctrl_pkg;

    // All segments dark (active-low)
    localparam logic [6:0] SEG_OFF = 7'h7F;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_SCAN = 2'd1,
        ST_GAP  = 2'd2
    } scan_state_e;

    // Hex nibble to active-low segments, bit 6 = g ... bit 0 = a
    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// rtl/seg_hex_decode.sv - combinational hex nibble to active-low 7-segment decode
module seg_hex_decode
    import seg_scan_ctrl_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // Pure table lookup, shared glyph definitions
    always_comb begin
        seg = hex_glyph(hex);
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed seven-segment scan controller with frame-synchronous update
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int NDIG     = 4,
    parameter int SCAN_DIV = 1000,
    parameter int GAP_CYC  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [4*NDIG-1:0] wr_data,
    input  logic [NDIG-1:0]   wr_blank,
    output logic [6:0]        seg,
    output logic [NDIG-1:0]   an
);

    localparam int CNT_MAX   = (SCAN_DIV > GAP_CYC) ? SCAN_DIV : GAP_CYC;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    localparam int PTR_W     = $clog2(NDIG);
    localparam int GAP_LAST  = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

    localparam logic [CNT_W-1:0] SCAN_END = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_END  = CNT_W'(GAP_LAST);
    localparam logic [PTR_W-1:0] PTR_END  = PTR_W'(NDIG - 1);

    scan_state_e         state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                pending_q, pending_d;
    logic [4*NDIG-1:0]   stage_data_q, stage_data_d;
    logic [NDIG-1:0]     stage_blank_q, stage_blank_d;
    logic [4*NDIG-1:0]   disp_data_q, disp_data_d;
    logic [NDIG-1:0]     disp_blank_q, disp_blank_d;
    logic [6:0]          seg_q, seg_d;
    logic [NDIG-1:0]     an_q, an_d;
    logic                frame_wrap;
    logic [6:0]          glyph;

    assign wr_ready = ~pending_q;
    assign seg      = seg_q;
    assign an       = an_q;

    seg_hex_decode u_decode (
        .hex (disp_data_q[4*ptr_q +: 4]),
        .seg (glyph)
    );

    // Scan FSM: slot/gap timing, digit pointer and frame-wrap detection
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        frame_wrap = 1'b0;
        case (state_q)
            ST_OFF: begin
                if (en) begin
                    state_d = ST_SCAN;
                    ptr_d   = '0;
                    cnt_d   = '0;
                end
            end
            ST_SCAN: begin
                if (cnt_q == SCAN_END) begin
                    cnt_d = '0;
                    if (GAP_CYC == 0) begin
                        if (ptr_q == PTR_END) begin
                            ptr_d      = '0;
                            frame_wrap = 1'b1;
                        end else begin
                            ptr_d = ptr_q + 1'b1;
                        end
                    end else begin
                        state_d = ST_GAP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_END) begin
                    cnt_d   = '0;
                    state_d = ST_SCAN;
                    if (ptr_q == PTR_END) begin
                        ptr_d      = '0;
                        frame_wrap = 1'b1;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_OFF;
            end
        endcase
        if (!en) begin
            state_d = ST_OFF;
            ptr_d   = '0;
            cnt_d   = '0;
        end
    end

    // Update handshake: stage on accept, commit only at a frame boundary or while off
    always_comb begin
        pending_d     = pending_q;
        stage_data_d  = stage_data_q;
        stage_blank_d = stage_blank_q;
        disp_data_d   = disp_data_q;
        disp_blank_d  = disp_blank_q;
        if (pending_q) begin
            if ((state_q == ST_OFF) || frame_wrap) begin
                disp_data_d  = stage_data_q;
                disp_blank_d = stage_blank_q;
                pending_d    = 1'b0;
            end
        end else if (wr_valid) begin
            stage_data_d  = wr_data;
            stage_blank_d = wr_blank;
            pending_d     = 1'b1;
        end
    end

    // Next output pattern from the current state and pointer (one registered stage)
    always_comb begin
        seg_d = SEG_OFF;
        an_d  = '1;
        if (state_q == ST_SCAN) begin
            an_d  = ~(NDIG'(1) << ptr_q);
            seg_d = disp_blank_q[ptr_q] ? SEG_OFF : glyph;
        end
    end

    // State and output registers; reset darkens the display and drops any pending update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_OFF;
            ptr_q         <= '0;
            cnt_q         <= '0;
            pending_q     <= 1'b0;
            stage_data_q  <= '0;
            stage_blank_q <= '1;
            disp_data_q   <= '0;
            disp_blank_q  <= '1;
            seg_q         <= SEG_OFF;
            an_q          <= '1;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            cnt_q         <= cnt_d;
            pending_q     <= pending_d;
            stage_data_q  <= stage_data_d;
            stage_blank_q <= stage_blank_d;
            disp_data_q   <= disp_data_d;
            disp_blank_q  <= disp_blank_d;
            seg_q         <= seg_d;
            an_q          <= an_d;
        end
    end

endmodule
